// File: rtl/pipe_pkg.sv
// Shared definitions for the obstacle-field scheduler, height lookup and obstacle renderer.
// Slot count and index width are fixed to match the five-entry height lookup tables.
package pipe_pkg;

    localparam int NUM_SLOTS     = 5;
    localparam int IDX_W         = 3;
    localparam int PITCH_DEFAULT = 160;
    localparam int SCORE_W_DEF   = 10;
    localparam int SCROLL_W      = 10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FROZEN = 2'd2
    } sched_state_t;

    // Next rotation index, wrapping from NUM_SLOTS-1 back to 0.
    function automatic logic [IDX_W-1:0] slot_next(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(NUM_SLOTS - 1)) ? '0 : idx + IDX_W'(1);
    endfunction

endpackage

// File: rtl/slot_ring_counter.sv
// Modulo-NUM_SLOTS rotation counter with synchronous clear (priority) and enable.
module slot_ring_counter
    import pipe_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [IDX_W-1:0] idx
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx <= '0;
        end else if (clr) begin
            idx <= '0;
        end else if (en) begin
            idx <= slot_next(idx);
        end
    end

endmodule

// File: rtl/pipe_scroll_sched.sv
// Obstacle-field scheduler: scrolls the pipe field per frame, steps the pipe/coin rotation
// indices each time a pitch scrolls past, and tracks which on-screen coins remain.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | after reset, waiting for start; field static
//   ST_RUN    | game running; frame ticks scroll the field, collects apply
//   ST_FROZEN | bird crashed; field held until the next start
module pipe_scroll_sched
    import pipe_pkg::*;
#(
    parameter int PITCH   = PITCH_DEFAULT,
    parameter int SCORE_W = SCORE_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame_tick,
    input  logic                 start,
    input  logic                 crash,
    input  logic [2:0]           speed,
    input  logic [NUM_SLOTS-1:0] collect,
    output logic [IDX_W-1:0]     pipe_idx,
    output logic [IDX_W-1:0]     coin_idx,
    output logic [SCROLL_W-1:0]  scroll_x,
    output logic [NUM_SLOTS-1:0] coin_valid,
    output logic                 advance,
    output logic [SCORE_W-1:0]   pass_count,
    output logic                 running
);

    sched_state_t state, state_nxt;

    logic                 in_run;
    logic                 reinit;
    logic                 wrap;
    logic [SCROLL_W:0]    sum;
    logic [SCROLL_W-1:0]  scroll_nxt;
    logic [NUM_SLOTS-1:0] cv_kept;
    logic [NUM_SLOTS-1:0] cv_nxt;
    logic [SCORE_W-1:0]   pass_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_RUN;
            ST_RUN:    if (crash) state_nxt = ST_FROZEN;
            ST_FROZEN: if (start) state_nxt = ST_RUN;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    assign in_run  = (state == ST_RUN);
    assign running = in_run;
    // Start only re-initialises when it actually enters RUN; a start while running is ignored.
    assign reinit  = start && (state == ST_IDLE || state == ST_FROZEN);
    assign sum     = {1'b0, scroll_x} + (SCROLL_W + 1)'(speed);
    assign wrap    = in_run && frame_tick && (sum >= (SCROLL_W + 1)'(PITCH));
    assign cv_kept = coin_valid & ~collect;

    always_comb begin
        scroll_nxt = scroll_x;
        cv_nxt     = coin_valid;
        pass_nxt   = pass_count;
        if (reinit) begin
            scroll_nxt = '0;
            cv_nxt     = '1;
            pass_nxt   = '0;
        end else if (in_run) begin
            // Collect applies to the pre-shift slots; the shift then retires slot 0.
            cv_nxt = cv_kept;
            if (wrap) begin
                scroll_nxt = SCROLL_W'(sum - (SCROLL_W + 1)'(PITCH));
                cv_nxt     = {1'b1, cv_kept[NUM_SLOTS-1:1]};
                pass_nxt   = (pass_count == '1) ? pass_count : pass_count + SCORE_W'(1);
            end else if (frame_tick) begin
                scroll_nxt = sum[SCROLL_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scroll_x   <= '0;
            coin_valid <= '1;
            pass_count <= '0;
            advance    <= 1'b0;
        end else begin
            scroll_x   <= scroll_nxt;
            coin_valid <= cv_nxt;
            pass_count <= pass_nxt;
            advance    <= wrap;
        end
    end

    slot_ring_counter u_pipe_ctr (
        .clk   (clk),
        .reset (reset),
        .clr   (reinit),
        .en    (wrap),
        .idx   (pipe_idx)
    );

    slot_ring_counter u_coin_ctr (
        .clk   (clk),
        .reset (reset),
        .clr   (reinit),
        .en    (wrap),
        .idx   (coin_idx)
    );

endmodule

// File: tb/tb_pipe_scroll_sched.sv
// Bench for pipe_scroll_sched: directed stimulus; expected post-advance state is queued
// by the stimulus and checked by a monitor whenever the DUT pulses advance.
module tb_pipe_scroll_sched;

    logic       clk;
    logic       reset;
    logic       frame_tick;
    logic       start;
    logic       crash;
    logic [2:0] speed;
    logic [4:0] collect;
    logic [2:0] pipe_idx;
    logic [2:0] coin_idx;
    logic [9:0] scroll_x;
    logic [4:0] coin_valid;
    logic       advance;
    logic [9:0] pass_count;
    logic       running;

    typedef struct {
        int scroll;
        int pidx;
        int cidx;
        int cv;
        int pass;
    } exp_t;

    exp_t sbq[$];
    int   total    = 0;
    int   passed   = 0;
    int   adv_seen = 0;

    int t3_scr[5]  = '{1, 2, 3, 4, 5};
    int t3_idx[5]  = '{3, 4, 0, 1, 2};
    int t3_cv[5]   = '{5'b10000, 5'b11000, 5'b11100, 5'b11110, 5'b11111};
    int t3_pass[5] = '{3, 4, 5, 6, 7};

    pipe_scroll_sched dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .start      (start),
        .crash      (crash),
        .speed      (speed),
        .collect    (collect),
        .pipe_idx   (pipe_idx),
        .coin_idx   (coin_idx),
        .scroll_x   (scroll_x),
        .coin_valid (coin_valid),
        .advance    (advance),
        .pass_count (pass_count),
        .running    (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    task automatic push_exp(input int s, input int p, input int c, input int cv, input int pc);
        exp_t e;
        e.scroll = s;
        e.pidx   = p;
        e.cidx   = c;
        e.cv     = cv;
        e.pass   = pc;
        sbq.push_back(e);
    endtask

    task automatic cyc(input logic ft, input logic st, input logic cr, input logic [4:0] col);
        frame_tick = ft;
        start      = st;
        crash      = cr;
        collect    = col;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        start      = 1'b0;
        crash      = 1'b0;
        collect    = 5'b0;
    endtask

    task automatic tick_n(input int n, input logic [4:0] col_last);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, 1'b0, 1'b0, (i == n - 1) ? col_last : 5'b0);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && advance) begin
            adv_seen++;
            if (sbq.size() == 0) begin
                total++;
                $display("FAIL unexpected_advance: got advance=1 required 0 (t=%0t)", $time);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("adv_scroll_x",   scroll_x,   e.scroll);
                chk("adv_pipe_idx",   pipe_idx,   e.pidx);
                chk("adv_coin_idx",   coin_idx,   e.cidx);
                chk("adv_coin_valid", coin_valid, e.cv);
                chk("adv_pass_count", pass_count, e.pass);
            end
        end
    end

    initial begin
        reset      = 1'b1;
        frame_tick = 1'b0;
        start      = 1'b0;
        crash      = 1'b0;
        speed      = 3'd0;
        collect    = 5'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pipe_idx",   pipe_idx,   0);
        chk("rst_coin_idx",   coin_idx,   0);
        chk("rst_scroll_x",   scroll_x,   0);
        chk("rst_coin_valid", coin_valid, 5'b11111);
        chk("rst_advance",    advance,    0);
        chk("rst_pass_count", pass_count, 0);
        chk("rst_running",    running,    0);
        reset = 1'b0;

        // idle ignores ticks
        tick_n(3, 5'b00011);
        chk("idle_scroll_x",   scroll_x,   0);
        chk("idle_coin_valid", coin_valid, 5'b11111);

        // 1: ten ticks at speed 4
        cyc(1'b0, 1'b1, 1'b0, 5'b0);
        chk("t1_running_start", running, 1);
        speed = 3'd4;
        tick_n(10, 5'b0);
        chk("t1_scroll_x", scroll_x, 40);
        chk("t1_pipe_idx", pipe_idx, 0);
        chk("t1_running",  running,  1);
        chk("t1_adv_seen", adv_seen, 0);

        // 2: speed 7, up to the pitch boundary then across it
        speed = 3'd7;
        tick_n(17, 5'b0);
        chk("t2_scroll_159", scroll_x, 159);
        push_exp(6, 1, 1, 5'b11111, 1);
        tick_n(1, 5'b0);
        cyc(1'b0, 1'b0, 1'b0, 5'b0);
        chk("t2_adv_low",  advance,  0);
        chk("t2_adv_seen", adv_seen, 1);
        tick_n(21, 5'b0);
        chk("t2_scroll_153", scroll_x, 153);
        push_exp(0, 2, 2, 5'b11111, 2);
        tick_n(1, 5'b0);

        // 3: collect all coins, then five advances refill and wrap the indices
        cyc(1'b0, 1'b0, 1'b0, 5'b11111);
        chk("t3_cv_cleared", coin_valid, 0);
        for (int k = 0; k < 5; k++) begin
            push_exp(t3_scr[k], t3_idx[k], t3_idx[k], t3_cv[k], t3_pass[k]);
            tick_n(23, 5'b0);
        end
        cyc(1'b0, 1'b0, 1'b0, 5'b0);
        chk("t3_cv_full",  coin_valid, 5'b11111);
        chk("t3_pipe_idx", pipe_idx,   2);
        chk("t3_adv_seen", adv_seen,   7);

        // 4: collect coinciding with advance
        push_exp(6, 3, 3, 5'b11101, 8);
        tick_n(23, 5'b00100);
        push_exp(0, 4, 4, 5'b11110, 9);
        tick_n(22, 5'b00001);
        cyc(1'b0, 1'b0, 1'b0, 5'b0);
        chk("t4_coin_valid", coin_valid, 5'b11110);

        // 5: crash freezes, start with tick re-initialises
        tick_n(3, 5'b0);
        cyc(1'b0, 1'b0, 1'b1, 5'b0);
        chk("t5_running_frozen", running, 0);
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 1'b0, 5'b11111);
        chk("t5_scroll_x",   scroll_x,   21);
        chk("t5_pipe_idx",   pipe_idx,   4);
        chk("t5_coin_idx",   coin_idx,   4);
        chk("t5_coin_valid", coin_valid, 5'b11110);
        chk("t5_pass_count", pass_count, 9);
        chk("t5_adv_seen",   adv_seen,   9);
        cyc(1'b1, 1'b1, 1'b0, 5'b0);
        chk("t5_re_scroll",  scroll_x,   0);
        chk("t5_re_pipe",    pipe_idx,   0);
        chk("t5_re_coin",    coin_idx,   0);
        chk("t5_re_cv",      coin_valid, 5'b11111);
        chk("t5_re_pass",    pass_count, 0);
        chk("t5_re_running", running,    1);

        // 6: reset lands while a wrapping tick is pending
        tick_n(22, 5'b0);
        speed = 3'd5;
        tick_n(1, 5'b0);
        chk("t6_scroll_159", scroll_x, 159);
        speed      = 3'd7;
        frame_tick = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        chk("t6_async_scroll",  scroll_x, 0);
        chk("t6_async_running", running,  0);
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        chk("t6_rst_advance",  advance,    0);
        chk("t6_rst_pipe_idx", pipe_idx,   0);
        chk("t6_rst_pass",     pass_count, 0);
        reset = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 5'b0);
        chk("t6_idle_running", running, 0);
        chk("t6_idle_advance", advance, 0);
        cyc(1'b0, 1'b1, 1'b0, 5'b0);
        tick_n(2, 5'b0);
        chk("t6_scroll_14", scroll_x, 14);
        cyc(1'b0, 1'b1, 1'b1, 5'b0);
        chk("t6_crash_wins", running, 0);
        tick_n(3, 5'b0);
        chk("t6_frozen_scroll", scroll_x, 14);
        cyc(1'b0, 1'b1, 1'b0, 5'b0);
        chk("t6_restart_running", running,  1);
        chk("t6_restart_scroll",  scroll_x, 0);

        cyc(1'b0, 1'b0, 1'b0, 5'b0);
        chk("sb_empty",       sbq.size(), 0);
        chk("final_adv_seen", adv_seen,   9);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
